// File: rtl/gps_track_pkg.sv
// Shared definitions for the GPS tracking/search blocks: code geometry,
// default datapath widths and the search controller state encoding.
package gps_track_pkg;

  localparam int SAMPLES_PER_CHIP = 16;
  localparam int CHIPS_PER_CODE   = 1023;
  localparam int SHIFT_MAX_DEF    = SAMPLES_PER_CHIP * CHIPS_PER_CODE - 1;

  localparam int SHIFT_W_DEF = 15;
  localparam int ACC_W_DEF   = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_DISCARD,
    ST_MEASURE,
    ST_NEXT,
    ST_DONE
  } search_state_t;

endpackage

// File: rtl/acc_magnitude.sv
// Absolute value of a signed correlator accumulation, one bit narrower than
// the input; the most-negative code saturates to all-ones.
module acc_magnitude
  import gps_track_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] accumulator,
  output logic [ACC_W-2:0] mag
);

  logic [ACC_W-2:0] low;
  logic [ACC_W-2:0] neg_low;

  // For a negative input x = -2^(W-1) + low, |x| is the two's complement of low.
  always_comb begin
    low     = accumulator[ACC_W-2:0];
    neg_low = ~low + 1'b1;
    mag     = low;
    if (accumulator[ACC_W-1]) begin
      mag = (low == '0) ? '1 : neg_low;
    end
  end

endmodule

// File: rtl/code_search_ctrl.sv
// Sequential code-phase search: steps the subchannel across code shifts,
// keeps the strongest correlation and reports it with a detection flag.
//
// state   | meaning
// IDLE    | waiting for start, outputs cleared
// SEEK    | seek_en high, waiting for code_shift to reach cand
// DISCARD | dropping partial integrations after the seek
// MEASURE | next accumulation is scored against the best so far
// NEXT    | advance cand by STEP or finish the sweep
// DONE    | results held, start restarts
module code_search_ctrl
  import gps_track_pkg::*;
#(
  parameter int SHIFT_W      = SHIFT_W_DEF,
  parameter int ACC_W        = ACC_W_DEF,
  parameter int SHIFT_MAX    = SHIFT_MAX_DEF,
  parameter int STEP         = 8,
  parameter int SETTLE_DUMPS = 1,
  parameter int SEEK_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [ACC_W-2:0]   threshold,
  input  logic [SHIFT_W-1:0] code_shift,
  input  logic               acc_valid,
  input  logic [ACC_W-1:0]   accumulator,
  output logic               seek_en,
  output logic [SHIFT_W-1:0] seek_target,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               detected,
  output logic [SHIFT_W-1:0] best_shift,
  output logic [ACC_W-2:0]   best_mag
);

  localparam int TMO_W = $clog2(SEEK_TIMEOUT + 1);
  localparam int DMP_W = $clog2(SETTLE_DUMPS + 2);
  localparam logic [SHIFT_W:0]  SHIFT_LAST = (SHIFT_W + 1)'(SHIFT_MAX);
  localparam logic [SHIFT_W:0]  STEP_INC   = (SHIFT_W + 1)'(STEP);
  localparam logic [TMO_W-1:0]  TMO_LOAD   = TMO_W'(SEEK_TIMEOUT);
  localparam logic [DMP_W-1:0]  DMP_LOAD   = DMP_W'(SETTLE_DUMPS);

  search_state_t      state;
  logic [SHIFT_W-1:0] cand;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [DMP_W-1:0]   dmp_cnt;
  logic [ACC_W-2:0]   mag;
  logic [SHIFT_W:0]   nxt;

  acc_magnitude #(.ACC_W(ACC_W)) u_mag (
    .accumulator(accumulator),
    .mag        (mag)
  );

  // One extra bit so the last step past SHIFT_MAX cannot wrap back to 0.
  assign nxt = {1'b0, cand} + STEP_INC;

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state       <= ST_IDLE;
      cand        <= '0;
      tmo_cnt     <= '0;
      dmp_cnt     <= '0;
      seek_en     <= 1'b0;
      seek_target <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      detected    <= 1'b0;
      best_shift  <= '0;
      best_mag    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state       <= ST_SEEK;
            cand        <= '0;
            tmo_cnt     <= TMO_LOAD;
            seek_en     <= 1'b1;
            seek_target <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            detected    <= 1'b0;
            best_shift  <= '0;
            best_mag    <= '0;
          end
        end
        ST_SEEK: begin
          if (code_shift == cand) begin
            seek_en <= 1'b0;
            tmo_cnt <= '0;
            dmp_cnt <= DMP_LOAD;
            state   <= (SETTLE_DUMPS == 0) ? ST_MEASURE : ST_DISCARD;
          end else if (tmo_cnt == '0) begin
            seek_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            error    <= 1'b1;
            detected <= (best_mag >= threshold);
            state    <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end
        ST_DISCARD: begin
          if (acc_valid) begin
            dmp_cnt <= dmp_cnt - 1'b1;
            if (dmp_cnt == DMP_W'(1)) state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (acc_valid) begin
            if (mag > best_mag) begin
              best_mag   <= mag;
              best_shift <= cand;
            end
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (nxt > SHIFT_LAST) begin
            busy     <= 1'b0;
            done     <= 1'b1;
            detected <= (best_mag >= threshold);
            state    <= ST_DONE;
          end else begin
            cand        <= nxt[SHIFT_W-1:0];
            seek_target <= nxt[SHIFT_W-1:0];
            seek_en     <= 1'b1;
            tmo_cnt     <= TMO_LOAD;
            state       <= ST_SEEK;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_search_ctrl.sv
// Directed bench for code_search_ctrl with a small subchannel model that acks
// seeks after three cycles and strobes accumulations from a per-shift table.
module tb_code_search_ctrl;

  localparam int SHIFT_W = 15;
  localparam int ACC_W   = 19;

  logic                      clk = 1'b0;
  logic                      reset, start, abort, acc_valid;
  logic [ACC_W-2:0]          threshold;
  logic [SHIFT_W-1:0]        code_shift;
  logic signed [ACC_W-1:0]   accumulator;
  logic                      seek_en, busy, done, error, detected;
  logic [SHIFT_W-1:0]        seek_target, best_shift;
  logic [ACC_W-2:0]          best_mag;

  int checks   = 0;
  int failures = 0;

  logic signed [ACC_W-1:0] acc_tab [8];
  int                      strobe_period;
  logic [SHIFT_W-1:0]      never_ack;
  logic [SHIFT_W-1:0]      seek_log [$];
  int                      seek_cyc_32;
  logic                    seek_en_q;

  code_search_ctrl #(
    .SHIFT_W(SHIFT_W), .ACC_W(ACC_W), .SHIFT_MAX(63), .STEP(8),
    .SETTLE_DUMPS(1), .SEEK_TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .threshold(threshold), .code_shift(code_shift), .acc_valid(acc_valid),
    .accumulator(accumulator), .seek_en(seek_en), .seek_target(seek_target),
    .busy(busy), .done(done), .error(error), .detected(detected),
    .best_shift(best_shift), .best_mag(best_mag)
  );

  always #5 clk = ~clk;

  // Subchannel model and seek monitor, all on the falling edge.
  initial begin : subchannel_model
    int age;
    int phase;
    age = 0;
    phase = 0;
    seek_en_q = 1'b0;
    forever begin
      @(negedge clk);
      if (seek_en === 1'b1 && seek_en_q !== 1'b1) seek_log.push_back(seek_target);
      if (seek_en === 1'b1 && seek_target == 15'd32) seek_cyc_32++;
      seek_en_q = seek_en;
      if (seek_en === 1'b1) begin
        age++;
        if (age == 3 && seek_target != never_ack) code_shift = seek_target;
      end else begin
        age = 0;
      end
      if (strobe_period != 0) begin
        phase++;
        if (phase >= strobe_period) begin
          phase = 0;
          acc_valid = 1'b1;
          accumulator = acc_tab[code_shift[5:3]];
        end else begin
          acc_valid = 1'b0;
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_wait: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({seek_en, busy, done, error, detected} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b, required 00000", {seek_en, busy, done, error, detected});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({seek_target, best_shift, best_mag} !== '0) begin
      failures++;
      $display("FAIL reset_regs: target=%0d shift=%0d mag=%0d, required 0", seek_target, best_shift, best_mag);
    end
  endtask

  task automatic test_peak();
    bit order_ok;
    threshold = 18'd50;
    acc_tab = '{19'sd10, 19'sd10, 19'sd10, 19'sd100, 19'sd10, 19'sd10, 19'sd10, 19'sd10};
    seek_log.delete();
    pulse_start();
    checks++;
    if (!(seek_en === 1'b1 && busy === 1'b1 && seek_target === 15'd0)) begin
      failures++;
      $display("FAIL start_latency: seek_en=%b busy=%b target=%0d, required 1 1 0", seek_en, busy, seek_target);
    end
    wait_done();
    order_ok = (seek_log.size() == 8);
    foreach (seek_log[i]) if (seek_log[i] != 15'(i * 8)) order_ok = 1'b0;
    checks++;
    if (!order_ok) begin
      failures++;
      $display("FAIL peak_seek_order: %0d seeks logged, required 8 ascending by 8", seek_log.size());
    end
    checks++;
    if (best_shift !== 15'd24 || best_mag !== 18'd100) begin
      failures++;
      $display("FAIL peak_best: shift=%0d mag=%0d, required 24 100", best_shift, best_mag);
    end
    checks++;
    if ({detected, error, busy} !== 3'b100) begin
      failures++;
      $display("FAIL peak_flags: det/err/busy=%b, required 100", {detected, error, busy});
    end
  endtask

  task automatic test_tie();
    threshold = 18'd78;
    acc_tab = '{19'sd10, 19'sd10, 19'sd77, 19'sd10, 19'sd10, 19'sd77, 19'sd10, 19'sd10};
    seek_log.delete();
    pulse_start();
    wait_done();
    checks++;
    if (best_shift !== 15'd16 || best_mag !== 18'd77) begin
      failures++;
      $display("FAIL tie_best: shift=%0d mag=%0d, required 16 77", best_shift, best_mag);
    end
    checks++;
    if (detected !== 1'b0) begin
      failures++;
      $display("FAIL tie_detect: detected=%b, required 0", detected);
    end
  endtask

  task automatic test_negative();
    threshold = 18'd50;
    acc_tab = '{19'sd10, 19'h40000, 19'sd10, 19'sd10, 19'sd10, -19'sd1000, 19'sd10, 19'sd10};
    seek_log.delete();
    pulse_start();
    wait_done();
    checks++;
    if (best_shift !== 15'd8 || best_mag !== 18'h3FFFF) begin
      failures++;
      $display("FAIL neg_saturate: shift=%0d mag=%h, required 8 3ffff", best_shift, best_mag);
    end
    checks++;
    if (detected !== 1'b1) begin
      failures++;
      $display("FAIL neg_detect: detected=%b, required 1", detected);
    end
  endtask

  task automatic test_timeout();
    threshold = 18'd50;
    never_ack = 15'd32;
    seek_cyc_32 = 0;
    acc_tab = '{19'sd10, 19'sd10, 19'sd55, 19'sd20, 19'sd200, 19'sd200, 19'sd200, 19'sd200};
    seek_log.delete();
    pulse_start();
    wait_done();
    checks++;
    if ({done, error, busy} !== 3'b110) begin
      failures++;
      $display("FAIL tmo_flags: done/err/busy=%b, required 110", {done, error, busy});
    end
    checks++;
    if (seek_cyc_32 != 21 || seek_log.size() != 5) begin
      failures++;
      $display("FAIL tmo_seek_cycles: cycles=%0d seeks=%0d, required 21 5", seek_cyc_32, seek_log.size());
    end
    checks++;
    if (best_shift !== 15'd16 || best_mag !== 18'd55 || detected !== 1'b1) begin
      failures++;
      $display("FAIL tmo_best: shift=%0d mag=%0d det=%b, required 16 55 1", best_shift, best_mag, detected);
    end
    never_ack = '1;
  endtask

  task automatic test_ignore();
    bit order_ok;
    threshold = 18'd50;
    strobe_period = 2;
    acc_tab = '{19'sd10, 19'sd10, 19'sd10, 19'sd100, 19'sd10, 19'sd10, 19'sd10, 19'sd10};
    seek_log.delete();
    pulse_start();
    repeat (30) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL ignore_midsweep: busy=%b, required 1", busy);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    order_ok = (seek_log.size() == 8);
    foreach (seek_log[i]) if (seek_log[i] != 15'(i * 8)) order_ok = 1'b0;
    checks++;
    if (!order_ok) begin
      failures++;
      $display("FAIL ignore_seek_order: %0d seeks logged, required 8 ascending by 8", seek_log.size());
    end
    checks++;
    if (best_shift !== 15'd24 || best_mag !== 18'd100 || error !== 1'b0) begin
      failures++;
      $display("FAIL ignore_best: shift=%0d mag=%0d err=%b, required 24 100 0", best_shift, best_mag, error);
    end
    strobe_period = 5;
  endtask

  task automatic test_abort();
    int n;
    acc_tab = '{19'sd10, 19'sd10, 19'sd10, 19'sd10, 19'sd10, 19'sd10, 19'sd10, 19'sd10};
    seek_log.delete();
    pulse_start();
    n = 0;
    while (!(seek_en === 1'b1 && seek_target == 15'd40) && n < 500) begin
      @(negedge clk);
      n++;
    end
    strobe_period = 0;
    acc_valid = 1'b0;
    while (!(seek_en === 1'b0 && busy === 1'b1 && seek_target == 15'd40) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 500) begin
      failures++;
      $display("FAIL abort_reach40: target=%0d seek_en=%b after %0d cycles, required DISCARD at 40", seek_target, seek_en, n);
    end
    acc_valid = 1'b1;
    @(negedge clk);
    acc_valid = 1'b0;
    checks++;
    if (best_mag !== 18'd10) begin
      failures++;
      $display("FAIL abort_pre_best: mag=%0d, required 10", best_mag);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy, seek_en, done, error} !== 4'b0 || best_mag !== 18'd0) begin
      failures++;
      $display("FAIL abort_clear: busy/seek/done/err=%b mag=%0d, required 0000 0", {busy, seek_en, done, error}, best_mag);
    end
    strobe_period = 5;
    seek_log.delete();
    pulse_start();
    wait_done();
    checks++;
    if (!(seek_log.size() == 8 && seek_log[0] == 15'd0) || best_mag !== 18'd10) begin
      failures++;
      $display("FAIL abort_restart: seeks=%0d mag=%0d, required 8 from 0 and 10", seek_log.size(), best_mag);
    end
    pulse_start();
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, seek_en, done} !== 3'b0 || best_mag !== 18'd0) begin
      failures++;
      $display("FAIL reset_midsweep: busy/seek/done=%b mag=%0d, required 000 0", {busy, seek_en, done}, best_mag);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    acc_valid = 1'b0;
    accumulator = '0;
    code_shift = '0;
    threshold = '0;
    strobe_period = 5;
    never_ack = '1;
    seek_cyc_32 = 0;
    for (int i = 0; i < 8; i++) acc_tab[i] = 19'sd10;
    test_reset();
    test_peak();
    test_tie();
    test_negative();
    test_timeout();
    test_ignore();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
